// File: rtl/occ_rom_responder.sv
// Occ-table responder: owns the 32-bit Occ rows (A/C/G/T byte lanes),
// clears them after reset, takes loader writes and serves 2-cycle reads.
module occ_rom_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_rom_Occ,
    input  logic [ADDR_W-1:0] addr_rom_Occ,
    output logic              rd_ready,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              wr_en,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              init_done
);

    localparam int LANES = 4;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_we;
    logic              ld_we;
    logic              rd_accept;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] row;
    logic [DATA_W-1:0] fetched;
    logic              fwd_hit;

    // State register; reset always restarts the clear sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_next = state;
        rd_ready   = 1'b0;
        init_done  = 1'b0;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == LAST_ROW) begin
                    state_next = READY;
                end
            end
            READY: begin
                rd_ready  = 1'b1;
                init_done = 1'b1;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Clear sweep row pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (clr_we) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign ld_we     = wr_en & (state == READY);
    assign rd_accept = ce_rom_Occ & rd_ready;

    // Table storage: clear sweep has priority, loader writes per lane
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_cnt] <= '0;
            end else if (ld_we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_be[i]) begin
                        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Stage 1: register the accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_accept;
        end
        s1_addr <= addr_rom_Occ;
    end

    // Row fetch with same-edge write forwarding per lane
    always_comb begin
        row     = mem[s1_addr];
        fwd_hit = ld_we & (wr_addr == s1_addr);
        fetched = row;
        for (int i = 0; i < LANES; i++) begin
            if (fwd_hit && wr_be[i]) begin
                fetched[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Stage 2: response register; data holds between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= s1_valid;
            if (s1_valid) begin
                data <= fetched;
            end
        end
    end

endmodule

// File: tb/tb_occ_rom_responder.sv
// Testbench for occ_rom_responder: directed scenarios plus a randomized
// read/write mix against a row-array reference model.
module tb_occ_rom_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [7:0]  addr = '0;
    logic        rd_ready;
    logic [31:0] data;
    logic        data_valid;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_be = '0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        init_done;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] last_data;

    occ_rom_responder #(
        .DEPTH(256),
        .ADDR_W(8),
        .DATA_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce_rom_Occ(ce),
        .addr_rom_Occ(addr),
        .rd_ready(rd_ready),
        .data(data),
        .data_valid(data_valid),
        .wr_en(wr_en),
        .wr_be(wr_be),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [3:0] be,
                               input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] be,
                            input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        tick();
        wr_en = 1'b0;
        model_write(a, be, d);
    endtask

    // single read; returns valid after each of the 3 edges and data
    task automatic read_row(input logic [7:0] a, output logic [2:0] v,
                            output logic [31:0] d1, output logic [31:0] d2);
        ce = 1'b1; addr = a;
        tick();
        ce = 1'b0;
        v[2] = data_valid;
        tick();
        v[1] = data_valid; d1 = data;
        tick();
        v[0] = data_valid; d2 = data;
    endtask

    // 256 edges after rst release: counts cycles where status rose early
    task automatic run_clear(output int early, output logic done_end);
        early = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (init_done !== 1'b0 || rd_ready !== 1'b0 || data_valid !== 1'b0)
                early++;
        end
        tick();
        done_end = init_done & rd_ready;
        model_clear();
    endtask

    task automatic test_reset();
        int early;
        logic done_end;
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({rd_ready, data_valid, init_done} !== 3'b000 || data !== 32'h0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b done=%b data=%h want 0 0 0 0",
                     rd_ready, data_valid, init_done, data);
        else n_pass++;
        rst = 1'b0;
        run_clear(early, done_end);
        n_total++;
        if (early !== 0)
            $display("FAIL clear_early: %0d early status cycles, want 0", early);
        else n_pass++;
        n_total++;
        if (done_end !== 1'b1)
            $display("FAIL clear_done: got %b after 256 cycles, want 1", done_end);
        else n_pass++;
        last_data = 32'h0;
    endtask

    task automatic test_clear_reads();
        logic [2:0] v;
        logic [31:0] d1, d2;
        logic [7:0] rows [3];
        rows[0] = 8'd0; rows[1] = 8'd128; rows[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            read_row(rows[i], v, d1, d2);
            n_total++;
            if (v !== 3'b010)
                $display("FAIL clear_read_valid row %0d: got %b want 010", rows[i], v);
            else n_pass++;
            n_total++;
            if (d1 !== ref_mem[rows[i]] || d2 !== ref_mem[rows[i]])
                $display("FAIL clear_read_data row %0d: got %h/%h want %h",
                         rows[i], d1, d2, ref_mem[rows[i]]);
            else n_pass++;
        end
        last_data = 32'h0;
    endtask

    task automatic test_full_write();
        logic [2:0] v;
        logic [31:0] d1, d2;
        do_write(8'd5, 4'hF, 32'h04030201);
        read_row(8'd5, v, d1, d2);
        n_total++;
        if (v !== 3'b010 || d1 !== 32'h04030201)
            $display("FAIL full_write: got v=%b data=%h want 010 04030201", v, d1);
        else n_pass++;
        n_total++;
        if ({d1[31:24], d1[23:16], d1[15:8], d1[7:0]} !== {8'd4, 8'd3, 8'd2, 8'd1})
            $display("FAIL lanes_acgt: got A=%0d C=%0d G=%0d T=%0d want 1 2 3 4",
                     d1[7:0], d1[15:8], d1[23:16], d1[31:24]);
        else n_pass++;
        last_data = d1;
    endtask

    task automatic test_lane_write();
        logic [2:0] v;
        logic [31:0] d1, d2;
        do_write(8'd5, 4'b0100, 32'h00AA0000);
        read_row(8'd5, v, d1, d2);
        n_total++;
        if (v !== 3'b010 || d1 !== 32'h04AA0201)
            $display("FAIL lane_write: got v=%b data=%h want 010 04AA0201", v, d1);
        else n_pass++;
        do_write(8'd5, 4'b0000, 32'hFFFFFFFF);
        read_row(8'd5, v, d1, d2);
        n_total++;
        if (d1 !== ref_mem[5])
            $display("FAIL be_zero: got %h want %h", d1, ref_mem[5]);
        else n_pass++;
        last_data = ref_mem[5];
    endtask

    task automatic test_back_to_back();
        logic [2:0] v;
        logic [31:0] d [3];
        logic v0;
        do_write(8'd1, 4'hF, 32'h11);
        do_write(8'd2, 4'hF, 32'h22);
        do_write(8'd3, 4'hF, 32'h33);
        ce = 1'b1; addr = 8'd1;
        tick();
        v0 = data_valid;
        addr = 8'd2;
        tick();
        v[2] = data_valid; d[0] = data;
        addr = 8'd3;
        tick();
        v[1] = data_valid; d[1] = data;
        ce = 1'b0;
        tick();
        v[0] = data_valid; d[2] = data;
        tick();
        n_total++;
        if (v0 !== 1'b0 || v !== 3'b111 || data_valid !== 1'b0)
            $display("FAIL b2b_valid: got %b,%b,%b want 0,111,0", v0, v, data_valid);
        else n_pass++;
        n_total++;
        if (d[0] !== 32'h11 || d[1] !== 32'h22 || d[2] !== 32'h33 || data !== 32'h33)
            $display("FAIL b2b_order: got %h %h %h hold %h want 11 22 33 33",
                     d[0], d[1], d[2], data);
        else n_pass++;
        last_data = 32'h33;
    endtask

    task automatic test_forward();
        logic [2:0] v;
        logic [31:0] d1, d2, pd;
        do_write(8'd9, 4'hF, 32'h13572468);
        ce = 1'b1; addr = 8'd9;
        tick();
        ce = 1'b0;
        wr_en = 1'b1; wr_addr = 8'd9; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        model_write(8'd9, 4'hF, 32'hDEADBEEF);
        n_total++;
        if (data_valid !== 1'b1 || data !== 32'hDEADBEEF)
            $display("FAIL fwd_t1: got v=%b data=%h want 1 DEADBEEF", data_valid, data);
        else n_pass++;
        tick();
        do_write(8'd9, 4'hF, 32'h13572468);
        ce = 1'b1; addr = 8'd9;
        tick();
        ce = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 8'd9; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        model_write(8'd9, 4'hF, 32'hDEADBEEF);
        n_total++;
        if (data !== 32'h13572468 || data_valid !== 1'b0)
            $display("FAIL fwd_t2: got v=%b data=%h want 0 13572468", data_valid, data);
        else n_pass++;
        pd = $urandom;
        ce = 1'b1; addr = 8'd9;
        tick();
        ce = 1'b0;
        wr_en = 1'b1; wr_addr = 8'd9; wr_be = 4'b0011; wr_data = pd;
        tick();
        wr_en = 1'b0;
        model_write(8'd9, 4'b0011, pd);
        n_total++;
        if (data_valid !== 1'b1 || data !== ref_mem[9])
            $display("FAIL fwd_lanes: got v=%b data=%h want 1 %h", data_valid, data, ref_mem[9]);
        else n_pass++;
        tick();
        read_row(8'd9, v, d1, d2);
        n_total++;
        if (d1 !== ref_mem[9])
            $display("FAIL fwd_stored: got %h want %h", d1, ref_mem[9]);
        else n_pass++;
        last_data = ref_mem[9];
    endtask

    task automatic test_random();
        logic [7:0] pend_a [$];
        int pend_e [$];
        int edge_no;
        logic exp_v;
        logic [31:0] exp_d;
        logic r_ce, r_we;
        logic [7:0] r_a, r_wa;
        logic [3:0] r_be;
        logic [31:0] r_wd;
        int bad_v, bad_d;
        edge_no = 0;
        bad_v = 0;
        bad_d = 0;
        for (int k = 0; k < 502; k++) begin
            r_ce = (k < 500) && ($urandom_range(0, 2) != 0);
            r_we = (k < 500) && ($urandom_range(0, 1) != 0);
            r_a  = 8'($urandom_range(0, 7)) + (($urandom_range(0, 1) != 0) ? 8'd248 : 8'd0);
            r_wa = 8'($urandom_range(0, 7)) + (($urandom_range(0, 1) != 0) ? 8'd248 : 8'd0);
            r_be = 4'($urandom);
            r_wd = $urandom;
            ce = r_ce; addr = r_a;
            wr_en = r_we; wr_addr = r_wa; wr_be = r_be; wr_data = r_wd;
            tick();
            edge_no++;
            if (r_we) model_write(r_wa, r_be, r_wd);
            exp_v = 1'b0;
            exp_d = last_data;
            if (pend_e.size() > 0 && pend_e[0] == edge_no) begin
                exp_v = 1'b1;
                exp_d = ref_mem[pend_a[0]];
                void'(pend_e.pop_front());
                void'(pend_a.pop_front());
            end
            if (r_ce) begin
                pend_a.push_back(r_a);
                pend_e.push_back(edge_no + 1);
            end
            n_total++;
            if (data_valid !== exp_v || data !== exp_d) begin
                $display("FAIL random cycle %0d: got v=%b data=%h want v=%b data=%h",
                         k, data_valid, data, exp_v, exp_d);
            end else n_pass++;
            last_data = exp_d;
        end
        ce = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_reset_midclear();
        int early;
        logic done_end;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_clear(early, done_end);
        n_total++;
        if (early !== 0 || done_end !== 1'b1)
            $display("FAIL midclear_restart: early=%0d done=%b want 0 1", early, done_end);
        else n_pass++;
        last_data = 32'h0;
    endtask

    task automatic test_reset_inflight();
        int early;
        logic done_end;
        logic [2:0] v;
        logic [31:0] d1, d2;
        do_write(8'd7, 4'hF, 32'hCAFEF00D);
        ce = 1'b1; addr = 8'd7;
        tick();
        rst = 1'b1;
        tick();
        n_total++;
        if (data_valid !== 1'b0 || data !== 32'h0)
            $display("FAIL inflight_drop: got v=%b data=%h want 0 0", data_valid, data);
        else n_pass++;
        tick();
        n_total++;
        if (data_valid !== 1'b0 || rd_ready !== 1'b0)
            $display("FAIL inflight_same_edge: got v=%b rdy=%b want 0 0", data_valid, rd_ready);
        else n_pass++;
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 8'd0; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        run_clear(early, done_end);
        ce = 1'b0;
        wr_en = 1'b0;
        n_total++;
        if (early !== 0 || done_end !== 1'b1)
            $display("FAIL inflight_clear: early=%0d done=%b want 0 1", early, done_end);
        else n_pass++;
        tick();
        n_total++;
        if (data_valid !== 1'b0 || data !== 32'h0)
            $display("FAIL clear_ce_ignored: got v=%b data=%h want 0 0", data_valid, data);
        else n_pass++;
        read_row(8'd0, v, d1, d2);
        n_total++;
        if (v !== 3'b010 || d1 !== ref_mem[0])
            $display("FAIL clear_wr_ignored: got v=%b data=%h want 010 %h", v, d1, ref_mem[0]);
        else n_pass++;
        read_row(8'd7, v, d1, d2);
        n_total++;
        if (d1 !== ref_mem[7])
            $display("FAIL row_recleared: got %h want %h", d1, ref_mem[7]);
        else n_pass++;
    endtask

    initial begin
        model_clear();
        last_data = 32'h0;
        test_reset();
        test_clear_reads();
        test_full_write();
        test_lane_write();
        test_back_to_back();
        test_forward();
        test_random();
        test_reset_midclear();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/occ_rom_responder.md
Name: occ_rom_responder

Overview:
- Responder side of the Occ-table read interface: serves the 32-bit Occ rows requested by the get_data stages via ce_rom_Occ/addr_rom_Occ.
- Each row packs four 8-bit counts: A in [7:0], C in [15:8], G in [23:16], T in [31:24].
- Owns the table storage. Clears it after reset, accepts byte-lane writes from the loader, and returns read data through a fixed 2-cycle pipeline with a valid strobe.

Parameters:
- DEPTH, 256: number of Occ rows.
- ADDR_W, 8: address width; DEPTH must equal 2**ADDR_W.
- DATA_W, 32: row width; fixed as 4 lanes of 8 bits.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce_rom_Occ  in  1  read request enable.
- addr_rom_Occ  in  ADDR_W  read row address (requester sends k-1).
- rd_ready  out  1  responder can accept a read this cycle.
- data  out  DATA_W  read row returned to the requester.
- data_valid  out  1  data carries a fresh read result this cycle.
- wr_en  in  1  loader write strobe.
- wr_be  in  4  per-lane write enables; bit n selects data[8n+7:8n].
- wr_addr  in  ADDR_W  write row address.
- wr_data  in  DATA_W  write row data.
- init_done  out  1  clear sequence finished; table usable.

Behaviour:
- Reset values while rst is high at a rising edge:
  - rd_ready=0, data=0, data_valid=0, init_done=0.
  - Clear counter = 0; state = CLEAR.
  - All in-flight pipeline entries discarded.
- State machine:
  - CLEAR: writes 32'h0 to row clr_cnt each cycle and increments clr_cnt. After writing row DEPTH-1, moves to READY.
  - READY: sets init_done=1 and rd_ready=1 from the first READY cycle. Stays in READY until rst.
- CLEAR timing:
  - Lasts exactly DEPTH cycles after reset deasserts.
  - init_done and rd_ready rise in cycle DEPTH+1 (256 cycles of clearing, then high).
  - rst asserted mid-CLEAR restarts CLEAR from row 0.
- Read acceptance:
  - A read is accepted at an edge where ce_rom_Occ=1 and rd_ready=1.
  - ce_rom_Occ while rd_ready=0 is ignored; it produces no data_valid.
- Read latency:
  - Read accepted at edge t: address registered at t, row fetched at t+1.
  - data_valid=1 for exactly the cycle following edge t+1.
  - Fully pipelined: one accepted read per cycle, responses in request order.
- Hold behaviour:
  - data holds its last value when data_valid=0.
  - data_valid is 0 in any cycle with no corresponding accepted read.
- Writes:
  - Take effect in READY only; wr_en during CLEAR is ignored.
  - A write updates only the lanes whose wr_be bit is 1.
  - wr_be=0 with wr_en=1 leaves the row unchanged.
- Read/write ordering:
  - A read fetched at edge t+1 reflects every write at edges up to and including t+1.
  - A same-edge write to the fetched row is forwarded per lane: enabled lanes take wr_data, others take stored data.
  - A write at edge t+2 or later does not alter an already fetched result.
- Address range:
  - Addresses are modulo DEPTH. Address 8'hFF (k=0 minus 1) is an ordinary row.
  - The loader keeps row 255 zero when Occ(-1)=0 is required.
- Reset mid-read: pending responses are dropped and data_valid stays 0. A request accepted in the same cycle as rst is discarded.

Test Plan:
- Reset, then hold rst=0 -> init_done=0 for 256 cycles, then 1. Reads of rows 0, 128 and 255 return 32'h0 with data_valid 2 cycles after acceptance.
- Write row 5 = 32'h04030201 (wr_be=4'hF), then read row 5 -> data=32'h04030201; lanes A=1, C=2, G=3, T=4.
- Row 5 = 32'h04030201, write wr_be=4'b0100, wr_data=32'h00AA0000, then read -> 32'h04AA0201.
- Back-to-back reads of rows 1, 2, 3 on consecutive cycles (rows hold 11, 22, 33) -> data_valid high 3 consecutive cycles, data 11, 22, 33 in order.
- Read row 9 accepted at t, write row 9 = 32'hDEADBEEF (be=4'hF) at t+1 -> response DEADBEEF. Repeat with write at t+2 -> old value returned.
- Assert rst during CLEAR at cycle 100, and again with 2 reads in flight -> clear restarts (init_done after 256 more cycles), no data_valid pulse, rd_ready=0 throughout CLEAR.
